// File: rtl/rlgl_game_n.sv
// Red-light/green-light game core for N players: per-player step lanes, round FSM,
// winner / elimination arbitration and a round-robin position display scan.

module rlgl_lane #(
  parameter int POS_W = 4,
  parameter int CLK_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CLK_W-1:0] mc_i,
  input  logic [POS_W-1:0] ms_i,
  output logic [POS_W-1:0] pos_nxt_o
);
  logic [CLK_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;

  always_comb begin
    cnt_d = cnt_q;
    pos_d = pos_q;
    if (clr_i) begin
      cnt_d = '0;
      pos_d = '0;
    end else if (inc_i) begin
      // >= rather than == keeps the counter bounded if max_clicks drops mid-round
      if (({1'b0, cnt_q} + 1'b1) >= {1'b0, mc_i}) begin
        cnt_d = '0;
        if (pos_q < ms_i) pos_d = pos_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      pos_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end

  assign pos_nxt_o = pos_d;
endmodule

module rlgl_game_n #(
  parameter int N_PLAYERS    = 4,
  parameter int POS_W        = 4,
  parameter int CLK_W        = 4,
  parameter int RED_MODE     = 0,
  parameter int TIMER_W      = 16,
  parameter int GREEN_CYCLES = 200,
  parameter int RED_CYCLES   = 100,
  parameter int SCAN_CYCLES  = 8,
  localparam int SEL_W       = $clog2(N_PLAYERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] clicks,
  input  logic [CLK_W-1:0]     max_clicks,
  input  logic [POS_W-1:0]     max_steps,
  input  logic                 red_toggle,
  output logic [1:0]           out_red_light,
  output logic [SEL_W-1:0]     out_player_sel,
  output logic [POS_W-1:0]     out_position,
  output logic [3:0]           out_status_code,
  output logic [N_PLAYERS-1:0] out_alive,
  output logic [SEL_W-1:0]     out_winner_id
);
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  // Encoding doubles as the out_red_light code.
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_GREEN = 2'b01, S_RED = 2'b10, S_FIN = 2'b11} state_e;

  state_e                          state_q;
  logic [N_PLAYERS-1:0]            prev_q, alive_q;
  logic [SEL_W-1:0]                winner_q, sel_q, sel_d;
  logic                            fin_win_q;
  logic [TIMER_W-1:0]              timer_q;
  logic [SCAN_W-1:0]               scan_q, scan_d;
  logic [POS_W-1:0]                position_q;

  logic [N_PLAYERS-1:0]            edges, inc, alive_red;
  logic [N_PLAYERS-1:0][POS_W-1:0] pos_nxt;
  logic [CLK_W-1:0]                mc_eff;
  logic [POS_W-1:0]                ms_eff;
  logic                            win_any;
  logic [SEL_W-1:0]                win_idx;

  assign mc_eff    = (max_clicks == '0) ? CLK_W'(1) : max_clicks;
  assign ms_eff    = (max_steps == '0) ? POS_W'(1) : max_steps;
  assign edges     = clicks & ~prev_q;
  assign inc       = (state_q == S_GREEN && !start) ? (edges & alive_q) : '0;
  assign alive_red = alive_q & ~edges;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_lane
    rlgl_lane #(.POS_W(POS_W), .CLK_W(CLK_W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (start),
      .inc_i    (inc[g]),
      .mc_i     (mc_eff),
      .ms_i     (ms_eff),
      .pos_nxt_o(pos_nxt[g])
    );
  end

  // Descending scan so the lowest finishing index is the one left standing.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (alive_q[i] && pos_nxt[i] >= ms_eff) begin
        win_any = 1'b1;
        win_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    scan_d = scan_q + 1'b1;
    sel_d  = sel_q;
    if (scan_q == SCAN_W'(SCAN_CYCLES - 1)) begin
      scan_d = '0;
      sel_d  = (sel_q == SEL_W'(N_PLAYERS - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prev_q     <= '0;
      alive_q    <= '1;
      winner_q   <= '0;
      fin_win_q  <= 1'b0;
      timer_q    <= '0;
      scan_q     <= '0;
      sel_q      <= '0;
      position_q <= '0;
    end else begin
      prev_q     <= clicks;
      scan_q     <= scan_d;
      sel_q      <= sel_d;
      position_q <= pos_nxt[sel_d];
      if (start) begin
        state_q   <= S_GREEN;
        alive_q   <= '1;
        winner_q  <= '0;
        fin_win_q <= 1'b0;
        timer_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_GREEN: begin
            if (win_any) begin
              state_q   <= S_FIN;
              fin_win_q <= 1'b1;
              winner_q  <= win_idx;
            end else if (RED_MODE == 0) begin
              if (red_toggle) state_q <= S_RED;
            end else if (timer_q == TIMER_W'(GREEN_CYCLES - 1)) begin
              state_q <= S_RED;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          S_RED: begin
            alive_q <= alive_red;
            if (alive_red == '0) begin
              state_q   <= S_FIN;
              fin_win_q <= 1'b0;
              winner_q  <= '0;
            end else if (RED_MODE == 0) begin
              if (!red_toggle) state_q <= S_GREEN;
            end else if (timer_q == TIMER_W'(RED_CYCLES - 1)) begin
              state_q <= S_GREEN;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          S_FIN: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    unique case (state_q)
      S_IDLE:  out_status_code = 4'd0;
      S_GREEN: out_status_code = 4'd1;
      S_RED:   out_status_code = 4'd2;
      default: out_status_code = fin_win_q ? 4'd3 : 4'd4;
    endcase
  end

  assign out_red_light  = state_q;
  assign out_player_sel = sel_q;
  assign out_position   = position_q;
  assign out_alive      = alive_q;
  assign out_winner_id  = winner_q;
endmodule

// File: tb/tb_rlgl_game_n.sv
// Directed bench for rlgl_game_n: a round-level game model checked every cycle,
// plus hand-computed expectations and a timer-mode instance with a literal light pattern.

module tb_rlgl_game_n;
  logic       clk, rst, start, start_t, red_toggle;
  logic [3:0] clicks, max_clicks, max_steps;
  logic [1:0] out_red_light, out_red_light_t;
  logic [1:0] out_player_sel, out_player_sel_t, out_winner_id, out_winner_id_t;
  logic [3:0] out_position, out_position_t, out_status_code, out_status_code_t;
  logic [3:0] out_alive, out_alive_t;

  int errs = 0, checks = 0;

  rlgl_game_n dut (
    .clk(clk), .rst(rst), .start(start), .clicks(clicks), .max_clicks(max_clicks),
    .max_steps(max_steps), .red_toggle(red_toggle), .out_red_light(out_red_light),
    .out_player_sel(out_player_sel), .out_position(out_position),
    .out_status_code(out_status_code), .out_alive(out_alive), .out_winner_id(out_winner_id));

  rlgl_game_n #(.RED_MODE(1), .GREEN_CYCLES(5), .RED_CYCLES(3)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .clicks(4'b0000), .max_clicks(max_clicks),
    .max_steps(max_steps), .red_toggle(1'b0), .out_red_light(out_red_light_t),
    .out_player_sel(out_player_sel_t), .out_position(out_position_t),
    .out_status_code(out_status_code_t), .out_alive(out_alive_t), .out_winner_id(out_winner_id_t));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Round-level model: phase 0 idle, 1 green, 2 red, 3 finished; hits = counted edges.
  int       m_phase, m_winner, m_cyc;
  bit       m_win;
  bit [3:0] m_alive, m_prev;
  int       m_hits[4];

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int m_pos(input int i);
    int p;
    p = m_hits[i] / eff(int'(max_clicks));
    return (p > eff(int'(max_steps))) ? eff(int'(max_steps)) : p;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_winner = 0; m_cyc = 0; m_win = 0; m_alive = 4'hF; m_prev = 0;
    for (int i = 0; i < 4; i++) m_hits[i] = 0;
  endtask

  // Advance the model by the clock edge about to sample the current inputs.
  task automatic model_step();
    bit [3:0] e;
    int w;
    e = clicks & ~m_prev;
    m_prev = clicks;
    m_cyc++;
    if (start) begin
      m_phase = 1; m_win = 0; m_winner = 0; m_alive = 4'hF;
      for (int i = 0; i < 4; i++) m_hits[i] = 0;
    end else if (m_phase == 1) begin
      for (int i = 0; i < 4; i++) if (m_alive[i] && e[i]) m_hits[i]++;
      w = -1;
      for (int i = 3; i >= 0; i--) if (m_alive[i] && m_pos(i) >= eff(int'(max_steps))) w = i;
      if (w >= 0) begin
        m_phase = 3; m_win = 1; m_winner = w;
      end else if (red_toggle) m_phase = 2;
    end else if (m_phase == 2) begin
      m_alive = m_alive & ~e;
      if (m_alive == 0) begin
        m_phase = 3; m_win = 0; m_winner = 0;
      end else if (!red_toggle) m_phase = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  always begin
    @(posedge clk);
    #2;
    chk("red_light", 32'(out_red_light), 32'(m_phase));
    chk("status", 32'(out_status_code), 32'((m_phase == 3) ? (m_win ? 3 : 4) : m_phase));
    chk("alive", 32'(out_alive), 32'(m_alive));
    chk("winner", 32'(out_winner_id), 32'(m_winner));
    chk("player_sel", 32'(out_player_sel), 32'((m_cyc / 8) % 4));
    chk("position", 32'(out_position), 32'(m_pos((m_cyc / 8) % 4)));
  end

  initial begin
    bit found;
    rst = 0; start = 0; start_t = 0; red_toggle = 0; clicks = 0;
    max_clicks = 4'd2; max_steps = 4'd3;
    model_reset();
    @(negedge clk);
    chk("rst_light", 32'(out_red_light), 0);
    chk("rst_status", 32'(out_status_code), 0);
    chk("rst_alive", 32'(out_alive), 32'hF);
    chk("rst_pos", 32'(out_position), 0);
    @(negedge clk);
    rst = 1;

    // Timer-driven light: 5 green, 3 red, repeating.
    start_t = 1; tick(); start_t = 0;
    for (int k = 0; k < 16; k++) begin
      chk("timer_light", 32'(out_red_light_t), ((k % 8) < 5) ? 1 : 2);
      tick();
    end

    // Game 1: player 1 walks to the finish.
    start = 1; tick(); start = 0;
    chk("start_green", 32'(out_red_light), 1);
    for (int k = 1; k <= 6; k++) begin
      clicks = 4'b0010; tick(); clicks = 0; tick();
      if (k == 2) chk("m_pos1_a", 32'(m_pos(1)), 1);
      if (k == 4) chk("m_pos1_b", 32'(m_pos(1)), 2);
    end
    chk("g1_status", 32'(out_status_code), 3);
    chk("g1_winner", 32'(out_winner_id), 1);
    chk("g1_light", 32'(out_red_light), 3);
    repeat (32) tick();

    // Game 2: player 2 eliminated on first red cycle, then tie between 0 and 3.
    start = 1; tick(); start = 0;
    red_toggle = 1; tick();
    clicks = 4'b0100; tick(); clicks = 0;
    chk("g2_alive", 32'(out_alive), 32'b1011);
    red_toggle = 0; tick(); tick();
    for (int k = 0; k < 4; k++) begin
      clicks = 4'b0100; tick(); clicks = 0; tick();
    end
    chk("m_pos2_dead", 32'(m_pos(2)), 0);
    for (int k = 0; k < 6; k++) begin
      clicks = 4'b1001; tick(); clicks = 0; tick();
    end
    chk("g2_status", 32'(out_status_code), 3);
    chk("g2_winner", 32'(out_winner_id), 0);
    repeat (32) tick();

    // Game 3: everyone clicks on red.
    start = 1; tick(); start = 0;
    red_toggle = 1; tick();
    clicks = 4'b1111; tick(); clicks = 0;
    chk("g3_alive", 32'(out_alive), 0);
    chk("g3_status", 32'(out_status_code), 4);
    chk("g3_light", 32'(out_red_light), 3);
    red_toggle = 0; tick();
    start = 1; tick(); start = 0;
    chk("g3_restart_alive", 32'(out_alive), 32'hF);
    chk("g3_restart_light", 32'(out_red_light), 1);
    repeat (32) tick();

    // Held button counts once; one fresh edge completes a step.
    clicks = 4'b0001;
    repeat (50) tick();
    clicks = 0; tick();
    clicks = 4'b0001; tick(); clicks = 0; tick();
    chk("m_pos0_hold", 32'(m_pos(0)), 1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (out_player_sel == 2'd0) found = 1;
      else tick();
    end
    chk("hold_sel_found", 32'(found), 1);
    chk("hold_pos0", 32'(out_position), 1);

    // Asynchronous reset mid-round.
    #2 rst = 0;
    model_reset();
    #1;
    chk("arst_light", 32'(out_red_light), 0);
    chk("arst_status", 32'(out_status_code), 0);
    chk("arst_alive", 32'(out_alive), 32'hF);
    chk("arst_sel", 32'(out_player_sel), 0);
    chk("arst_pos", 32'(out_position), 0);
    @(negedge clk);
    rst = 1;

    // Zero limits behave as one: a single click wins.
    max_clicks = 0; max_steps = 0;
    start = 1; tick(); start = 0;
    clicks = 4'b0100; tick(); clicks = 0; tick();
    chk("zero_status", 32'(out_status_code), 3);
    chk("zero_winner", 32'(out_winner_id), 2);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
